// File: rtl/formal_output_checker.sv
// formal_output_checker: compares out_gfpga vs out_bench (masked by bench_valid) over RUN_CYCLES; reports mismatch_flag, nb_error, first_err_*, busy, done, pass
module formal_output_checker #(
  parameter int NUM_OUTPUTS = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int RUN_CYCLES  = 400
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_OUTPUTS-1:0] out_gfpga,
  input  logic [NUM_OUTPUTS-1:0] out_bench,
  input  logic [NUM_OUTPUTS-1:0] bench_valid,
  output logic [NUM_OUTPUTS-1:0] mismatch_flag,
  output logic [CNT_WIDTH-1:0]   nb_error,
  output logic [CNT_WIDTH-1:0]   first_err_cycle,
  output logic [NUM_OUTPUTS-1:0] first_err_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass
);
  typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RUN_CYCLES - 1);
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cyc_cnt_q, cyc_cnt_d, nb_error_q, nb_error_d, first_err_cycle_q, first_err_cycle_d;
  logic [NUM_OUTPUTS-1:0] mismatch_flag_q, mismatch_flag_d, first_err_vec_q, first_err_vec_d, mism, rise;
  logic                   err_seen_q, err_seen_d, pass_q, pass_d;
  assign mism = bench_valid & (out_gfpga ^ out_bench);
  assign rise = mism & ~mismatch_flag_q;
  always_comb begin
    state_d           = state_q;
    cyc_cnt_d         = cyc_cnt_q;
    nb_error_d        = nb_error_q;
    first_err_cycle_d = first_err_cycle_q;
    first_err_vec_d   = first_err_vec_q;
    mismatch_flag_d   = mismatch_flag_q;
    err_seen_d        = err_seen_q;
    pass_d            = pass_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d           = SKIP;
      nb_error_d        = '0;
      first_err_cycle_d = '0;
      first_err_vec_d   = '0;
      mismatch_flag_d   = '0;
      err_seen_d        = 1'b0;
      pass_d            = 1'b0;
    end else if (state_q == SKIP) begin
      state_d   = CHECK;
      cyc_cnt_d = '0;
    end else if (state_q == CHECK) begin
      mismatch_flag_d = mism;
      for (int i = 0; i < NUM_OUTPUTS; i++)
        if (rise[i] && !(&nb_error_d)) nb_error_d = nb_error_d + ONE;
      if (|mism && !err_seen_q) begin
        first_err_cycle_d = cyc_cnt_q;
        first_err_vec_d   = mism;
        err_seen_d        = 1'b1;
      end
      if (cyc_cnt_q == LAST) begin
        state_d = DONE;
        pass_d  = (nb_error_d == '0);
      end else cyc_cnt_d = cyc_cnt_q + ONE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q           <= IDLE;
      cyc_cnt_q         <= '0;
      nb_error_q        <= '0;
      first_err_cycle_q <= '0;
      first_err_vec_q   <= '0;
      mismatch_flag_q   <= '0;
      err_seen_q        <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      cyc_cnt_q         <= cyc_cnt_d;
      nb_error_q        <= nb_error_d;
      first_err_cycle_q <= first_err_cycle_d;
      first_err_vec_q   <= first_err_vec_d;
      mismatch_flag_q   <= mismatch_flag_d;
      err_seen_q        <= err_seen_d;
      pass_q            <= pass_d;
    end
  assign mismatch_flag   = mismatch_flag_q;
  assign nb_error        = nb_error_q;
  assign first_err_cycle = first_err_cycle_q;
  assign first_err_vec   = first_err_vec_q;
  assign pass            = pass_q;
  assign busy            = (state_q == SKIP) || (state_q == CHECK);
  assign done            = (state_q == DONE);
endmodule

// File: tb/tb_formal_output_checker.sv
// tb_formal_output_checker: directed and random runs on two checker instances against a cycle-array reference model
module tb_formal_output_checker;
  localparam int SAT = 15;
  logic clk, rst_n, start, start_s;
  logic [1:0] g, b, v;
  logic [1:0] flag, fvec, flag_s, fvec_s;
  logic [3:0] nb, fcyc, nb_s, fcyc_s;
  logic busy, done, pass, busy_s, done_s, pass_s;
  logic [1:0] g_a [16], b_a [16], v_a [16];
  int total = 0, bad = 0;
  formal_output_checker #(.NUM_OUTPUTS(2), .CNT_WIDTH(4), .RUN_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .out_gfpga(g), .out_bench(b), .bench_valid(v),
    .mismatch_flag(flag), .nb_error(nb), .first_err_cycle(fcyc), .first_err_vec(fvec),
    .busy(busy), .done(done), .pass(pass));
  formal_output_checker #(.NUM_OUTPUTS(2), .CNT_WIDTH(4), .RUN_CYCLES(15)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .out_gfpga(g), .out_bench(b), .bench_valid(v),
    .mismatch_flag(flag_s), .nb_error(nb_s), .first_err_cycle(fcyc_s), .first_err_vec(fvec_s),
    .busy(busy_s), .done(done_s), .pass(pass_s));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // Drives one run from g_a/b_a/v_a; the model walks the cycle arrays tracking previous mismatch vector.
  task automatic run(input bit s, input int n, input logic [1:0] skip_g, input int mid_start);
    logic [1:0] pm, m, fv;
    int cnt, fc;
    bit seen;
    pm = 0; cnt = 0; fc = 0; fv = 0; seen = 0;
    @(negedge clk);
    if (s) start_s = 1; else start = 1;
    g = 2'($urandom); b = 2'($urandom); v = 2'($urandom);
    @(negedge clk);
    start = 0; start_s = 0;
    chk("busy_after_start", 16'(s ? busy_s : busy), 1);
    g = skip_g; b = 0; v = 2'b11;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == mid_start) begin if (s) start_s = 1; else start = 1; end
      else begin start = 0; start_s = 0; end
      g = g_a[k]; b = b_a[k]; v = v_a[k];
      if (k == n - 1) chk("done_early", 16'(s ? done_s : done), 0);
      @(posedge clk);
      #1;
      m = v_a[k] & (g_a[k] ^ b_a[k]);
      for (int i = 0; i < 2; i++) if (m[i] && !pm[i]) cnt++;
      if (cnt > SAT) cnt = SAT;
      if (m != 0 && !seen) begin seen = 1; fc = k; fv = m; end
      pm = m;
      chk("flag_run", 16'(s ? flag_s : flag), 16'(m));
      chk("nb_run", 16'(s ? nb_s : nb), 16'(cnt));
    end
    start = 0; start_s = 0;
    chk("done", 16'(s ? done_s : done), 1);
    chk("busy_end", 16'(s ? busy_s : busy), 0);
    chk("pass", 16'(s ? pass_s : pass), 16'(cnt == 0));
    chk("first_cyc", 16'(s ? fcyc_s : fcyc), 16'(fc));
    chk("first_vec", 16'(s ? fvec_s : fvec), 16'(fv));
    @(negedge clk);
    g = 2'b11; b = 2'b00; v = 2'b11;
    repeat (2) @(negedge clk);
    chk("hold_nb", 16'(s ? nb_s : nb), 16'(cnt));
    chk("hold_flag", 16'(s ? flag_s : flag), 16'(pm));
    chk("hold_done", 16'(s ? done_s : done), 1);
  endtask
  task automatic fill_clean();
    for (int k = 0; k < 16; k++) begin
      g_a[k] = 2'($urandom); b_a[k] = g_a[k]; v_a[k] = 2'b11;
    end
  endtask
  initial begin
    rst_n = 0; start = 0; start_s = 0; g = 0; b = 0; v = 0;
    repeat (2) @(negedge clk);
    chk("rst_flag", 16'(flag), 0);
    chk("rst_nb", 16'(nb), 0);
    chk("rst_fcyc", 16'(fcyc), 0);
    chk("rst_fvec", 16'(fvec), 0);
    chk("rst_busy", 16'(busy), 0);
    chk("rst_done", 16'(done), 0);
    chk("rst_pass", 16'(pass), 0);
    rst_n = 1;
    // clean run
    fill_clean();
    run(0, 8, 2'b00, -1);
    // mismatch only on the skip sample
    fill_clean();
    run(0, 8, 2'b11, -1);
    // persistent then re-failing
    fill_clean();
    for (int k = 0; k < 8; k++) begin
      g_a[k] = 2'b00; b_a[k] = 2'b00;
    end
    g_a[2] = 2'b01; g_a[3] = 2'b01; g_a[4] = 2'b01; g_a[6] = 2'b11;
    run(0, 8, 2'b00, -1);
    chk("persist_nb", 16'(nb), 3);
    chk("persist_fvec", 16'(fvec), 16'h1);
    chk("persist_fcyc", 16'(fcyc), 2);
    // don't-care on bit0
    for (int k = 0; k < 16; k++) begin
      g_a[k] = 2'b01; b_a[k] = 2'b00; v_a[k] = 2'b10;
    end
    run(0, 8, 2'b00, -1);
    chk("dc_pass", 16'(pass), 1);
    // saturation: both bits toggling on the 15-cycle instance
    for (int k = 0; k < 16; k++) begin
      g_a[k] = (k % 2 == 0) ? 2'b11 : 2'b00; b_a[k] = 2'b00; v_a[k] = 2'b11;
    end
    run(1, 15, 2'b00, -1);
    chk("sat_nb", 16'(nb_s), 15);
    // random runs on both instances
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 16; k++) begin
        g_a[k] = 2'($urandom);
        b_a[k] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : g_a[k];
        v_a[k] = 2'($urandom);
      end
      run(r[0], r[0] ? 15 : 8, 2'($urandom), -1);
    end
    // reset mid-run
    @(negedge clk);
    start = 1; g = 2'b11; b = 2'b00; v = 2'b11;
    @(negedge clk);
    start = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_nb", 16'(nb), 2);
    chk("pre_rst_busy", 16'(busy), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_flag", 16'(flag), 0);
    chk("mid_rst_nb", 16'(nb), 0);
    chk("mid_rst_fvec", 16'(fvec), 0);
    chk("mid_rst_busy", 16'(busy), 0);
    chk("mid_rst_done", 16'(done), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", 16'(busy), 0);
    chk("idle_done", 16'(done), 0);
    // start during CHECK ignored, then identical rerun from DONE
    fill_clean();
    for (int k = 0; k < 8; k++) begin
      g_a[k] = 2'b00; b_a[k] = 2'b00;
    end
    g_a[1] = 2'b10; g_a[2] = 2'b10; g_a[5] = 2'b11;
    run(0, 8, 2'b00, 4);
    run(0, 8, 2'b00, -1);
    chk("rerun_nb", 16'(nb), 3);
    chk("rerun_fcyc", 16'(fcyc), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
